// File: rtl/imem_boot_loader.sv
// Boot image loader: parses header/address/data/checksum words from a stream,
// writes the data words into instruction memory and releases the CPU reset on success.
module imem_boot_loader #(
    parameter int          IMEM_WORDS = 1024,
    parameter int          ADDR_W     = 10,
    parameter logic [15:0] MAGIC      = 16'hB007
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wr_data,
    output logic              cpu_reset,
    output logic              boot_done,
    output logic              boot_error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_HDR, S_ADDR, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t            state, state_nxt;
    logic [15:0]       count;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       acc;
    logic              beat;
    logic              addr_bad;
    logic [16:0]       addr_end;
    logic              last_word;

    assign in_ready   = (state == S_HDR) || (state == S_ADDR) ||
                        (state == S_DATA) || (state == S_CHECK);
    assign beat       = in_valid & in_ready;
    assign cpu_reset  = (state != S_DONE);
    assign boot_done  = (state == S_DONE);
    assign boot_error = (state == S_ERROR);

    // Image must start word aligned, inside the addressable range, and end at or before the top.
    assign addr_end  = {{(17-ADDR_W){1'b0}}, in_data[ADDR_W+1:2]} + {1'b0, count};
    assign addr_bad  = (in_data[1:0] != 2'b00) ||
                       (in_data[31:ADDR_W+2] != '0) ||
                       (addr_end > 17'(IMEM_WORDS));
    assign last_word = (words_loaded == count - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_HDR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (beat) begin
            case (state)
                S_HDR:   state_nxt = (in_data[31:16] != MAGIC) ? S_ERROR : S_ADDR;
                S_ADDR:  begin
                    if (addr_bad)         state_nxt = S_ERROR;
                    else if (count == '0) state_nxt = S_CHECK;
                    else                  state_nxt = S_DATA;
                end
                S_DATA:  if (last_word) state_nxt = S_CHECK;
                S_CHECK: state_nxt = (in_data == acc) ? S_DONE : S_ERROR;
                default: state_nxt = state;
            endcase
        end
    end

    // Write port is registered: a data beat shows up on imem one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_wr_en   <= 1'b0;
            imem_addr    <= '0;
            imem_wr_data <= '0;
            words_loaded <= '0;
            acc          <= '0;
            count        <= '0;
            word_addr    <= '0;
        end else begin
            imem_wr_en <= 1'b0;
            if (beat) begin
                case (state)
                    S_HDR:  count     <= in_data[15:0];
                    S_ADDR: word_addr <= in_data[ADDR_W+1:2];
                    S_DATA: begin
                        imem_wr_en   <= 1'b1;
                        imem_addr    <= word_addr + words_loaded[ADDR_W-1:0];
                        imem_wr_data <= in_data;
                        acc          <= acc ^ in_data;
                        words_loaded <= words_loaded + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: valid images, header/address/checksum
// rejects, empty images, valid gaps and mid-image reset.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        imem_wr_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wr_data;
    logic        cpu_reset;
    logic        boot_done;
    logic        boot_error;
    logic [15:0] words_loaded;

    int n_cmp = 0;
    int n_err = 0;
    int wr_count = 0;
    int wr_base;

    imem_boot_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_addr    (imem_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_reset    (cpu_reset),
        .boot_done    (boot_done),
        .boot_error   (boot_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_wr_en === 1'b1) wr_count++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [9:0] a, input logic [31:0] d);
        chk({tag, "_en"}, 32'(imem_wr_en), 32'd1);
        chk({tag, "_addr"}, 32'(imem_addr), 32'(a));
        chk({tag, "_data"}, imem_wr_data, d);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(imem_wr_en), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wr_data, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(boot_done), 32'd0);
        chk("rst_error", 32'(boot_error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Case 1: three words at byte address 0x10 -> imem 4,5,6
        wr_base = wr_count;
        beat(32'hB007_0003);
        chk("c1_hdr_nowr", 32'(imem_wr_en), 32'd0);
        beat(32'h0000_0010);
        beat(32'h2002_0001);
        chk_write("c1_w0", 10'd4, 32'h2002_0001);
        chk("c1_words1", 32'(words_loaded), 32'd1);
        beat(32'h2003_0002);
        chk_write("c1_w1", 10'd5, 32'h2003_0002);
        beat(32'h0043_0820);
        chk_write("c1_w2", 10'd6, 32'h0043_0820);
        chk("c1_words3", 32'(words_loaded), 32'd3);
        chk("c1_cpu_rst_hold", 32'(cpu_reset), 32'd1);
        beat(32'h0042_0823);
        chk("c1_done", 32'(boot_done), 32'd1);
        chk("c1_cpu_rst", 32'(cpu_reset), 32'd0);
        chk("c1_err", 32'(boot_error), 32'd0);
        chk("c1_ready", 32'(in_ready), 32'd0);
        chk("c1_chk_nowr", 32'(imem_wr_en), 32'd0);
        beat(32'h1111_1111);
        idle();
        chk("c1_extra_words", 32'(words_loaded), 32'd3);
        chk("c1_wr_count", 32'(wr_count - wr_base), 32'd3);

        // Case 2: bad magic
        do_reset();
        wr_base = wr_count;
        beat(32'hDEAD_0001);
        chk("c2_err", 32'(boot_error), 32'd1);
        chk("c2_ready", 32'(in_ready), 32'd0);
        chk("c2_cpu_rst", 32'(cpu_reset), 32'd1);
        beat(32'hB007_0003);
        beat(32'h0000_0000);
        idle();
        chk("c2_done", 32'(boot_done), 32'd0);
        chk("c2_wr_count", 32'(wr_count - wr_base), 32'd0);

        // Case 3: address checks
        do_reset();
        beat(32'hB007_0001);
        beat(32'h0000_0002);
        chk("c3a_misalign_err", 32'(boot_error), 32'd1);
        do_reset();
        beat(32'hB007_0002);
        beat(32'h0000_0FFC);
        chk("c3b_overflow_err", 32'(boot_error), 32'd1);
        do_reset();
        beat(32'hB007_0000);
        beat(32'h0000_1000);
        chk("c3c_highbits_err", 32'(boot_error), 32'd1);
        do_reset();
        wr_base = wr_count;
        beat(32'hB007_0001);
        beat(32'h0000_0FFC);
        chk("c3d_addr_ok", 32'(boot_error), 32'd0);
        beat(32'hA5A5_1234);
        chk_write("c3d_w", 10'd1023, 32'hA5A5_1234);
        beat(32'hA5A5_1234);
        chk("c3d_done", 32'(boot_done), 32'd1);
        chk("c3d_wr_count", 32'(wr_count - wr_base), 32'd1);

        // Case 4: empty image
        do_reset();
        wr_base = wr_count;
        beat(32'hB007_0000);
        beat(32'h0000_0000);
        beat(32'h0000_0000);
        chk("c4a_done", 32'(boot_done), 32'd1);
        chk("c4a_wr_count", 32'(wr_count - wr_base), 32'd0);
        do_reset();
        beat(32'hB007_0000);
        beat(32'h0000_0000);
        beat(32'h0000_0001);
        chk("c4b_err", 32'(boot_error), 32'd1);
        chk("c4b_done", 32'(boot_done), 32'd0);

        // Case 5: gaps between every beat, bad checksum
        do_reset();
        wr_base = wr_count;
        idle(); beat(32'hB007_0003);
        idle(); beat(32'h0000_0010);
        idle(); beat(32'h2002_0001);
        chk_write("c5_w0", 10'd4, 32'h2002_0001);
        idle();
        chk("c5_gap_nowr", 32'(imem_wr_en), 32'd0);
        chk("c5_gap_words", 32'(words_loaded), 32'd1);
        beat(32'h2003_0002);
        chk_write("c5_w1", 10'd5, 32'h2003_0002);
        idle(); beat(32'h0043_0820);
        chk_write("c5_w2", 10'd6, 32'h0043_0820);
        idle(); beat(32'h0042_0822);
        chk("c5_err", 32'(boot_error), 32'd1);
        chk("c5_cpu_rst", 32'(cpu_reset), 32'd1);
        chk("c5_words", 32'(words_loaded), 32'd3);
        idle();
        chk("c5_wr_count", 32'(wr_count - wr_base), 32'd3);

        // Case 6: asynchronous reset mid-image, then full resend
        do_reset();
        beat(32'hB007_0003);
        beat(32'h0000_0010);
        beat(32'h2002_0001);
        beat(32'h2003_0002);
        #2;
        reset = 1'b1;
        #1;
        chk("c6_wr_en", 32'(imem_wr_en), 32'd0);
        chk("c6_addr", 32'(imem_addr), 32'd0);
        chk("c6_wdata", imem_wr_data, 32'd0);
        chk("c6_words", 32'(words_loaded), 32'd0);
        chk("c6_cpu_rst", 32'(cpu_reset), 32'd1);
        chk("c6_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        beat(32'hB007_0003);
        beat(32'h0000_0010);
        beat(32'h2002_0001);
        chk_write("c6_w0", 10'd4, 32'h2002_0001);
        beat(32'h2003_0002);
        beat(32'h0043_0820);
        chk_write("c6_w2", 10'd6, 32'h0043_0820);
        beat(32'h0042_0823);
        chk("c6_done", 32'(boot_done), 32'd1);
        chk("c6_words3", 32'(words_loaded), 32'd3);
        chk("c6_cpu_rel", 32'(cpu_reset), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
